// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg: shared types and defaults for the instruction fetch stage.
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Prefetch buffer entry layout; the FIFO stores {pc, instr} in this order.
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter width able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo: synchronous prefetch FIFO, flush has priority over push/pop.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = PC_W_DEF + INSTR_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  // Head reads as zero when empty so the outputs have defined reset values.
  assign head  = empty ? '0 : slots[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit: fetch FSM, fetch PC, memory req/ack port and prefetch buffer.
// FETCH_STATS_EN adds stat_fetched / stat_redirects counters.  Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_redirects
`endif
);

  localparam int CNT_W = cnt_width(DEPTH);

  fetch_state_t             state;
  logic [PC_W-1:0]          fetch_pc;
  logic                     push;
  logic                     pop;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic [PC_W+INSTR_W-1:0]  head;
  int                       count_after;

  // A redirect cancels any same-cycle push or pop.
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign push        = (state == REQ) && mem_ack && !redirect_valid;
  assign count_after = int'(count) + 1 - int'(pop);
  assign instr_valid = !empty;
  assign {instr_pc, instr_out} = head;

  fetch_fifo #(
    .WIDTH (PC_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({mem_addr, mem_rdata}),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      fetch_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end else if (int'(count) < DEPTH) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            // An un-acked request cannot be retracted; wait it out in DROP.
            if (mem_ack) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (mem_ack) begin
            fetch_pc <= mem_addr + PC_W'(1);
            if (count_after < DEPTH) begin
              mem_addr <= mem_addr + PC_W'(1);
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched   <= '0;
      stat_redirects <= '0;
    end else begin
      if (pop)            stat_fetched   <= stat_fetched + 16'd1;
      if (redirect_valid) stat_redirects <= stat_redirects + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
